pong_match_controller: RTL and testbench

- Match-level sequencer for the Pong game.
- Runs the game state machine IDLE → SERVE → PLAY → POINT → … → GAME_OVER, and holds both players' scores.
- Holds the ball at centre outside PLAY, gates paddle motion, and selects the serve direction.
- Sits between the 30 Hz game tick, the ball/paddle datapath and the graphics/score overlay; runs entirely in the 50 MHz `clock` domain.

---
 rtl/pong_match_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_pong_match_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_controller.sv
// -----------------------------------------------------------------------------
// pong_match_controller
//
// Match-level sequencer for the Pong game. Steps the game through
// IDLE -> SERVE -> PLAY -> POINT -> ... -> GAME_OVER, keeps both players'
// scores, holds the ball at centre outside PLAY, gates paddle motion and
// chooses which way the next serve launches. Runs entirely in the 50 MHz
// `clock` domain; the 30 Hz game rate arrives as a one-cycle game_tick.
//
// Ports
//   clock          in   50 MHz system clock
//   resetApp       in   asynchronous, active-high reset
//   game_tick      in   one-cycle pulse at the game rate (synchronous)
//   start_n        in   start key, active-low, asynchronous to clock
//   ball_y [8:0]   in   current ball row, 0..LCD_HEIGHT-1
//   state [2:0]    out  IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4
//   ball_hold      out  1 = ball parked at centre
//   paddle_enable  out  1 = paddles may move (SERVE and PLAY)
//   serve_dir      out  0 = launch toward player 1 (top), 1 = toward player 2
//   score_1 [3:0]  out  player 1 score
//   score_2 [3:0]  out  player 2 score
//   point_pulse    out  one-cycle strobe on the cycle a point is scored
//   winner [1:0]   out  0 = none, 1 = player 1, 2 = player 2
// -----------------------------------------------------------------------------
module pong_match_controller #(
  parameter int LCD_HEIGHT  = 320,
  parameter int MAX_SCORE   = 10,
  parameter int GOAL_TOP    = 4,
  parameter int GOAL_BOTTOM = 315,
  parameter int SERVE_TICKS = 60,
  parameter int POINT_TICKS = 45
) (
  input  logic       clock,
  input  logic       resetApp,
  input  logic       game_tick,
  input  logic       start_n,
  input  logic [8:0] ball_y,
  output logic [2:0] state,
  output logic       ball_hold,
  output logic       paddle_enable,
  output logic       serve_dir,
  output logic [3:0] score_1,
  output logic [3:0] score_2,
  output logic       point_pulse,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  // The bottom goal line can never sit below the last visible row, otherwise
  // a ball travelling off the bottom of the screen would never score.
  localparam int GOAL_BOTTOM_ROW =
    (GOAL_BOTTOM > LCD_HEIGHT - 1) ? (LCD_HEIGHT - 1) : GOAL_BOTTOM;

  localparam logic [8:0] GOAL_TOP_Y    = 9'(GOAL_TOP);
  localparam logic [8:0] GOAL_BOTTOM_Y = 9'(GOAL_BOTTOM_ROW);
  localparam logic [3:0] MAX_SCORE_L   = 4'(MAX_SCORE);
  localparam logic [7:0] SERVE_TICKS_L = 8'(SERVE_TICKS);
  localparam logic [7:0] POINT_TICKS_L = 8'(POINT_TICKS);

  // ---------------------------------------------------------------------------
  // Start key: two-flop synchroniser, then falling-edge detect. The detect
  // output is registered so the event lands three clocks after the pin falls.
  // All flops reset to the released (high) level so a key held down through
  // reset is not mistaken for a fresh press.
  // ---------------------------------------------------------------------------
  logic start_meta_reg;
  logic start_sync_reg;
  logic start_prev_reg;
  logic start_evt_reg;

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      start_meta_reg <= 1'b1;
      start_sync_reg <= 1'b1;
      start_prev_reg <= 1'b1;
      start_evt_reg  <= 1'b0;
    end else begin
      start_meta_reg <= start_n;
      start_sync_reg <= start_meta_reg;
      start_prev_reg <= start_sync_reg;
      start_evt_reg  <= start_prev_reg & ~start_sync_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Match state and datapath registers
  // ---------------------------------------------------------------------------
  state_t     state_reg,       state_next;
  logic [7:0] tick_cnt_reg,    tick_cnt_next;
  logic [3:0] score_1_reg,     score_1_next;
  logic [3:0] score_2_reg,     score_2_next;
  logic       serve_dir_reg,   serve_dir_next;
  logic [1:0] winner_reg,      winner_next;
  logic       point_pulse_reg, point_pulse_next;
  logic       ball_hold_reg;
  logic       paddle_enable_reg;

  // Saturating increments: the tick counter pins at 255 and scores pin at
  // MAX_SCORE, so neither can ever wrap back to a small value.
  logic [7:0] tick_cnt_inc;
  logic [3:0] score_1_inc;
  logic [3:0] score_2_inc;
  logic       goal_top;
  logic       goal_bottom;

  assign tick_cnt_inc = (tick_cnt_reg == 8'hFF) ? tick_cnt_reg : tick_cnt_reg + 8'd1;
  assign score_1_inc  = (score_1_reg >= MAX_SCORE_L) ? score_1_reg : score_1_reg + 4'd1;
  assign score_2_inc  = (score_2_reg >= MAX_SCORE_L) ? score_2_reg : score_2_reg + 4'd1;
  assign goal_top     = (ball_y <= GOAL_TOP_Y);
  assign goal_bottom  = (ball_y >= GOAL_BOTTOM_Y);

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      state_reg         <= ST_IDLE;
      tick_cnt_reg      <= 8'd0;
      score_1_reg       <= 4'd0;
      score_2_reg       <= 4'd0;
      serve_dir_reg     <= 1'b0;
      winner_reg        <= 2'd0;
      point_pulse_reg   <= 1'b0;
      ball_hold_reg     <= 1'b1;
      paddle_enable_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      tick_cnt_reg      <= tick_cnt_next;
      score_1_reg       <= score_1_next;
      score_2_reg       <= score_2_next;
      serve_dir_reg     <= serve_dir_next;
      winner_reg        <= winner_next;
      point_pulse_reg   <= point_pulse_next;
      // Decoded from the next state so these registered flags change on the
      // same edge as the state they describe.
      ball_hold_reg     <= (state_next != ST_PLAY);
      paddle_enable_reg <= (state_next == ST_SERVE) || (state_next == ST_PLAY);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    tick_cnt_next    = tick_cnt_reg;
    score_1_next     = score_1_reg;
    score_2_next     = score_2_reg;
    serve_dir_next   = serve_dir_reg;
    winner_next      = winner_reg;
    point_pulse_next = 1'b0;

    case (state_reg)
      // A new match starts from either resting state. The start press takes
      // priority over a coincident game_tick, which is simply not counted.
      ST_IDLE, ST_GAME_OVER: begin
        if (start_evt_reg) begin
          state_next     = ST_SERVE;
          tick_cnt_next  = 8'd0;
          score_1_next   = 4'd0;
          score_2_next   = 4'd0;
          serve_dir_next = 1'b0;
          winner_next    = 2'd0;
        end
      end

      ST_SERVE: begin
        if (game_tick) begin
          if (tick_cnt_inc >= SERVE_TICKS_L) begin
            state_next    = ST_PLAY;
            tick_cnt_next = 8'd0;
          end else begin
            tick_cnt_next = tick_cnt_inc;
          end
        end
      end

      // Goals are judged only on game ticks, against the ball row seen on
      // that edge. The player who concedes receives the next serve.
      ST_PLAY: begin
        if (game_tick) begin
          if (goal_top) begin
            score_2_next     = score_2_inc;
            serve_dir_next   = 1'b0;
            point_pulse_next = 1'b1;
            tick_cnt_next    = 8'd0;
            if (score_2_inc == MAX_SCORE_L) begin
              state_next  = ST_GAME_OVER;
              winner_next = 2'd2;
            end else begin
              state_next = ST_POINT;
            end
          end else if (goal_bottom) begin
            score_1_next     = score_1_inc;
            serve_dir_next   = 1'b1;
            point_pulse_next = 1'b1;
            tick_cnt_next    = 8'd0;
            if (score_1_inc == MAX_SCORE_L) begin
              state_next  = ST_GAME_OVER;
              winner_next = 2'd1;
            end else begin
              state_next = ST_POINT;
            end
          end
        end
      end

      ST_POINT: begin
        if (game_tick) begin
          if (tick_cnt_inc >= POINT_TICKS_L) begin
            state_next    = ST_SERVE;
            tick_cnt_next = 8'd0;
          end else begin
            tick_cnt_next = tick_cnt_inc;
          end
        end
      end

      // Encodings 5..7 are unreachable in normal operation; recover to IDLE.
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs, all straight from registers
  // ---------------------------------------------------------------------------
  assign state         = state_reg;
  assign ball_hold     = ball_hold_reg;
  assign paddle_enable = paddle_enable_reg;
  assign serve_dir     = serve_dir_reg;
  assign score_1       = score_1_reg;
  assign score_2       = score_2_reg;
  assign point_pulse   = point_pulse_reg;
  assign winner        = winner_reg;

endmodule

// File: tb/tb_pong_match_controller.sv
// -----------------------------------------------------------------------------
// tb_pong_match_controller
//
// Scoreboard bench for pong_match_controller (MAX_SCORE=2, SERVE_TICKS=3,
// POINT_TICKS=2). Stimulus pushes hand-computed expected output snapshots into
// a queue. A monitor pops one entry whenever the DUT outputs change (sampled on
// the falling clock edge) or when stimulus requests an explicit probe, which
// pins down timing such as pulse width and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_pong_match_controller;

  logic       clock;
  logic       resetApp;
  logic       game_tick;
  logic       start_n;
  logic [8:0] ball_y;
  logic [2:0] state;
  logic       ball_hold;
  logic       paddle_enable;
  logic       serve_dir;
  logic [3:0] score_1;
  logic [3:0] score_2;
  logic       point_pulse;
  logic [1:0] winner;

  pong_match_controller #(
    .LCD_HEIGHT  (320),
    .MAX_SCORE   (2),
    .GOAL_TOP    (4),
    .GOAL_BOTTOM (315),
    .SERVE_TICKS (3),
    .POINT_TICKS (2)
  ) dut (
    .clock         (clock),
    .resetApp      (resetApp),
    .game_tick     (game_tick),
    .start_n       (start_n),
    .ball_y        (ball_y),
    .state         (state),
    .ball_hold     (ball_hold),
    .paddle_enable (paddle_enable),
    .serve_dir     (serve_dir),
    .score_1       (score_1),
    .score_2       (score_2),
    .point_pulse   (point_pulse),
    .winner        (winner)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       dir;
    logic [1:0] win;
    logic       pp;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  bit          probe_req = 1'b0;
  event        sample_now;
  logic [16:0] last_snap;
  logic [16:0] snap;

  assign snap = {state, score_1, score_2, serve_dir, winner,
                 ball_hold, paddle_enable, point_pulse};

  // ---------------------------------------------------------------- checking
  task automatic compare(input exp_t e);
    logic exp_hold;
    logic exp_pad;
    exp_hold = (e.st != 3'd2);
    exp_pad  = (e.st == 3'd1) || (e.st == 3'd2);
    checks++;
    if (state === e.st && score_1 === e.s1 && score_2 === e.s2 &&
        serve_dir === e.dir && winner === e.win && point_pulse === e.pp &&
        ball_hold === exp_hold && paddle_enable === exp_pad) begin
      passes++;
      $display("[%0t] ok   %s: st=%0d s1=%0d s2=%0d dir=%0d win=%0d hold=%0d pad=%0d pp=%0d",
               $time, e.name, state, score_1, score_2, serve_dir, winner,
               ball_hold, paddle_enable, point_pulse);
    end else begin
      $display("[%0t] FAIL %s: got st=%0d s1=%0d s2=%0d dir=%0d win=%0d hold=%0d pad=%0d pp=%0d, expected st=%0d s1=%0d s2=%0d dir=%0d win=%0d hold=%0d pad=%0d pp=%0d",
               $time, e.name, state, score_1, score_2, serve_dir, winner,
               ball_hold, paddle_enable, point_pulse,
               e.st, e.s1, e.s2, e.dir, e.win, exp_hold, exp_pad, e.pp);
    end
  endtask

  task automatic pop_and_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      $display("[%0t] FAIL unexpected_change: got st=%0d s1=%0d s2=%0d dir=%0d win=%0d pp=%0d, expected no output change",
               $time, state, score_1, score_2, serve_dir, winner, point_pulse);
    end else begin
      e = exp_q.pop_front();
      compare(e);
    end
  endtask

  // Monitor: one scoreboard pop per output change or per explicit probe.
  initial begin
    last_snap = '0;
    forever begin
      @(negedge clock or sample_now);
      if (probe_req) begin
        probe_req = 1'b0;
        pop_and_check();
        last_snap = snap;
      end else if (snap !== last_snap) begin
        pop_and_check();
        last_snap = snap;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  function automatic exp_t mk(input string name, input logic [2:0] st,
                              input logic [3:0] s1, input logic [3:0] s2,
                              input logic dir, input logic [1:0] win,
                              input logic pp);
    exp_t e;
    e.name = name;
    e.st   = st;
    e.s1   = s1;
    e.s2   = s2;
    e.dir  = dir;
    e.win  = win;
    e.pp   = pp;
    return e;
  endfunction

  // Expect the next output change to look like this.
  task automatic expect_change(input exp_t e);
    exp_q.push_back(e);
  endtask

  // Compare the outputs right now, whether or not they changed.
  task automatic probe(input exp_t e);
    exp_q.push_back(e);
    probe_req = 1'b1;
    ->sample_now;
  endtask

  // One game_tick, high across exactly one rising edge; returns 2 ns after it.
  task automatic tick();
    @(posedge clock);
    #2 game_tick = 1'b1;
    @(posedge clock);
    #2 game_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Hold start for 5 clocks; probe 4 clocks after the pin falls
  // (3 clocks to the start event, one more for the state to follow).
  task automatic press(input exp_t e);
    @(posedge clock);
    #2 start_n = 1'b0;
    repeat (4) @(posedge clock);
    #3 probe(e);
    @(posedge clock);
    #2 start_n = 1'b1;
  endtask

  // Same press, but with a game_tick landing on the start-event cycle.
  task automatic press_with_tick(input exp_t e);
    @(posedge clock);
    #2 start_n = 1'b0;
    repeat (3) @(posedge clock);
    #2 game_tick = 1'b1;
    @(posedge clock);
    #2 game_tick = 1'b0;
    #1 probe(e);
    @(posedge clock);
    #2 start_n = 1'b1;
  endtask

  // A scoring tick: the pulse is seen as a change, then must be gone one
  // clock later.
  task automatic score_tick(input logic [8:0] row, input exp_t hit, input exp_t after);
    ball_y = row;
    expect_change(hit);
    tick();
    @(posedge clock);
    #3 probe(after);
    ball_y = 9'd160;
  endtask

  initial begin
    resetApp  = 1'b0;
    game_tick = 1'b0;
    start_n   = 1'b1;
    ball_y    = 9'd160;

    // Reset and idle
    #1 resetApp = 1'b1;
    #4 probe(mk("reset", 0, 0, 0, 0, 0, 0));
    @(posedge clock);
    #2 resetApp = 1'b0;
    ticks(10);
    #1 probe(mk("idle_ignores_ticks", 0, 0, 0, 0, 0, 0));

    // Start and serve
    press(mk("start_to_serve", 1, 0, 0, 0, 0, 0));
    ticks(3);
    #1 probe(mk("serve_to_play", 2, 0, 0, 0, 0, 0));

    // Goal at top
    score_tick(9'd3, mk("goal_top", 3, 0, 1, 0, 0, 1),
               mk("goal_top_pulse_end", 3, 0, 1, 0, 0, 0));
    ticks(2);
    #1 probe(mk("point_to_serve", 1, 0, 1, 0, 0, 0));
    ticks(3);
    #1 probe(mk("serve_to_play_2", 2, 0, 1, 0, 0, 0));

    // Bottom edge and no-goal
    ball_y = 9'd314;
    tick();
    #1 probe(mk("no_goal_314", 2, 0, 1, 0, 0, 0));
    score_tick(9'd315, mk("goal_bottom_315", 3, 1, 1, 1, 0, 1),
               mk("goal_bottom_pulse_end", 3, 1, 1, 1, 0, 0));
    ticks(2);
    #1 probe(mk("point_to_serve_2", 1, 1, 1, 1, 0, 0));
    ticks(3);
    #1 probe(mk("serve_to_play_3", 2, 1, 1, 1, 0, 0));

    // Start press in PLAY is ignored
    press(mk("start_in_play_ignored", 2, 1, 1, 1, 0, 0));

    // Player 1 wins, scores frozen, restart
    score_tick(9'd315, mk("win_p1", 4, 2, 1, 1, 1, 1),
               mk("win_pulse_end", 4, 2, 1, 1, 1, 0));
    ball_y = 9'd3;
    ticks(3);
    #1 probe(mk("game_over_frozen", 4, 2, 1, 1, 1, 0));
    ball_y = 9'd160;
    press(mk("restart", 1, 0, 0, 0, 0, 0));
    ticks(3);
    #1 probe(mk("serve_to_play_4", 2, 0, 0, 0, 0, 0));

    // Reset while in POINT
    score_tick(9'd0, mk("goal_top_row0", 3, 0, 1, 0, 0, 1),
               mk("goal_top_row0_pulse_end", 3, 0, 1, 0, 0, 0));
    @(posedge clock);
    #3 resetApp = 1'b1;
    #2 probe(mk("reset_in_point", 0, 0, 0, 0, 0, 0));
    @(posedge clock);
    #2 resetApp = 1'b0;

    // Start and tick together in IDLE: start wins, tick not counted
    press_with_tick(mk("start_with_tick", 1, 0, 0, 0, 0, 0));
    ticks(2);
    #1 probe(mk("serve_count_from_zero", 1, 0, 0, 0, 0, 0));
    tick();
    #1 probe(mk("serve_to_play_5", 2, 0, 0, 0, 0, 0));

    // Every expected entry must have been consumed
    repeat (4) @(posedge clock);
    #3;
    checks++;
    if (exp_q.size() == 0) begin
      passes++;
      $display("[%0t] ok   queue_drained", $time);
    end else begin
      $display("[%0t] FAIL queue_drained: got %0d pending entries, expected 0",
               $time, exp_q.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
